// File: rtl/gates_lu_pipe_pkg.sv
// Shared definitions for the registered gates logic unit: opcode encoding and width.
package gates_lu_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/gates_lu_pipe_lu.sv
// Purely combinational bitwise logic unit: one of eight two-operand gate functions.
module gates_lu
    import gates_lu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        y = '0;
        case (op_e'(op))
            OP_AND:   y = a & b;
            OP_NAND:  y = ~(a & b);
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/gates_lu_pipe.sv
// Registered gates unit with valid/ready handshakes, accumulate mode and a
// saturating count of accepted transactions.
module gates_lu_pipe
    import gates_lu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_cnt
);

    logic             xfer;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] result;

    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;

    // A same-cycle clear takes effect before the accumulator is used as operand A.
    assign acc_base = acc_clr ? '0 : acc_q;
    assign eff_a    = acc ? acc_base : a;

    gates_lu #(.WIDTH(WIDTH)) u_lu (
        .a  (eff_a),
        .b  (b),
        .op (op),
        .y  (result)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            z         <= '0;
            out_valid <= 1'b0;
            acc_q     <= '0;
            txn_cnt   <= '0;
        end else if (xfer) begin
            z         <= result;
            out_valid <= 1'b1;
            acc_q     <= result;
            if (txn_cnt != '1) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_clr) begin
                acc_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gates_lu_pipe.sv
// Self-checking bench for gates_lu_pipe: opcode table, accumulate chain,
// backpressure, same-cycle clear, counter saturation and reset mid-stall.
module tb_gates_lu_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc;
    logic             acc_clr;
    logic [WIDTH-1:0] z;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] txn_cnt;

    gates_lu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc       (acc),
        .acc_clr   (acc_clr),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_q     (acc_q),
        .txn_cnt   (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] sb [$];
    int         applied;
    int         miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and the driver checks only at posedge+1; the scoreboard samples at negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL z_sb: result %0h consumed, no result expected (t=%0t)", z, $time);
            end else begin
                check("z_sb", 32'(z), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        applied     = 0;
        miscompares = 0;
        vecs[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
        vecs[1] = '{8'hF0, 8'hCC, 3'd1, 8'h3F};
        vecs[2] = '{8'hF0, 8'hCC, 3'd2, 8'hFC};
        vecs[3] = '{8'hF0, 8'hCC, 3'd3, 8'h03};
        vecs[4] = '{8'hF0, 8'hCC, 3'd4, 8'h3C};
        vecs[5] = '{8'hF0, 8'hCC, 3'd5, 8'hC3};
        vecs[6] = '{8'hF0, 8'hCC, 3'd6, 8'h0F};
        vecs[7] = '{8'hF0, 8'hCC, 3'd7, 8'hF0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_z", 32'(z), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_acc_q", 32'(acc_q), 32'h00);
        check("rst_txn_cnt", 32'(txn_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Opcode sweep, one transaction per cycle.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            sb.push_back(vecs[i].exp);
            step();
            check("sweep_out_valid", 32'(out_valid), 32'h1);
            check("sweep_z", 32'(z), 32'(vecs[i].exp));
        end
        in_valid = 1'b0;
        check("sweep_txn_cnt", 32'(txn_cnt), 32'h8);
        check("sweep_acc_q", 32'(acc_q), 32'hF0);

        // Accumulate chain after a clear pulse.
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check("clr_acc_q", 32'(acc_q), 32'h00);
        acc = 1'b1; op = 3'd2; a = 8'hA5; in_valid = 1'b1;
        begin
            logic [7:0] chain_b   [4];
            logic [7:0] chain_exp [4];
            chain_b   = '{8'h01, 8'h02, 8'h04, 8'h08};
            chain_exp = '{8'h01, 8'h03, 8'h07, 8'h0F};
            for (int i = 0; i < 4; i++) begin
                b = chain_b[i];
                sb.push_back(chain_exp[i]);
                step();
                check("chain_acc_q", 32'(acc_q), 32'(chain_exp[i]));
                check("chain_z", 32'(z), 32'(chain_exp[i]));
                check("chain_out_valid", 32'(out_valid), 32'h1);
            end
        end
        in_valid = 1'b0; acc = 1'b0;

        // Backpressure: stall three cycles with a new transaction waiting.
        a = 8'h11; b = 8'h22; op = 3'd2; in_valid = 1'b1;
        sb.push_back(8'h33);
        step();
        out_ready = 1'b0; a = 8'h0F; b = 8'hF0; op = 3'd4;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_z", 32'(z), 32'h33);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_acc_q", 32'(acc_q), 32'h33);
            check("stall_txn_cnt", 32'(txn_cnt), 32'hD);
        end
        out_ready = 1'b1;
        sb.push_back(8'hFF);
        step();
        check("release_z", 32'(z), 32'hFF);
        check("release_out_valid", 32'(out_valid), 32'h1);
        check("release_txn_cnt", 32'(txn_cnt), 32'hE);
        in_valid = 1'b0;

        // Same-cycle clear and accumulate transfer.
        a = 8'hAA; op = 3'd7; in_valid = 1'b1;
        sb.push_back(8'hAA);
        step();
        check("preload_acc_q", 32'(acc_q), 32'hAA);
        acc = 1'b1; acc_clr = 1'b1; op = 3'd4; b = 8'h55; a = 8'h00;
        sb.push_back(8'h55);
        step();
        in_valid = 1'b0; acc = 1'b0; acc_clr = 1'b0;
        check("clrxfer_z", 32'(z), 32'h55);
        check("clrxfer_acc_q", 32'(acc_q), 32'h55);
        check("clrxfer_txn_cnt", 32'(txn_cnt), 32'hF);

        // Counter saturation from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = vecs[i % 8].a; b = vecs[i % 8].b; op = vecs[i % 8].op; in_valid = 1'b1;
            sb.push_back(vecs[i % 8].exp);
            step();
            check("sat_txn_cnt", 32'(txn_cnt), (i + 1 > 15) ? 32'hF : 32'(i + 1));
        end
        in_valid = 1'b0;

        // Reset while a result is stalled.
        a = 8'h5A; op = 3'd7; in_valid = 1'b1;
        sb.push_back(8'h5A);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("prerst_out_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_z", 32'(z), 32'h00);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_acc_q", 32'(acc_q), 32'h00);
        check("midrst_txn_cnt", 32'(txn_cnt), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);

        out_ready = 1'b1;
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
